// File: rtl/ddfs_core_if.sv
// ddfs_core_if: control-word inputs and PCM/pulse output stream of the DDFS engine.
`default_nettype none

interface ddfs_core_if #(
    parameter int PHASE_WIDTH = 30,
    parameter int DATA_WIDTH  = 16
);
    logic                   i_en;
    logic [PHASE_WIDTH-1:0] i_fccw;
    logic [PHASE_WIDTH-1:0] i_focw;
    logic [PHASE_WIDTH-1:0] i_pha;
    logic [DATA_WIDTH-1:0]  i_env;
    logic [DATA_WIDTH-1:0]  o_pcm;
    logic                   o_pcm_valid;
    logic                   o_pulse;

    modport master (
        output i_en, i_fccw, i_focw, i_pha, i_env,
        input  o_pcm, o_pcm_valid, o_pulse
    );

    modport slave (
        input  i_en, i_fccw, i_focw, i_pha, i_env,
        output o_pcm, o_pcm_valid, o_pulse
    );
endinterface

`default_nettype wire

// File: rtl/ddfs_core.sv
// ===========================================================================
// ddfs_core: phase accumulator + ROM address issue + envelope/saturate stage.
// Optional phase dither via macro DDFS_DITHER_EN.       Revision: 1.0
// ===========================================================================
`default_nettype none

module ddfs_core #(
    parameter int PHASE_WIDTH = 30,
    parameter int ADDR_WIDTH  = 11,
    parameter int DATA_WIDTH  = 16
) (
    input  wire logic                  i_clk,
    input  wire logic                  i_rst_n,
    ddfs_core_if.slave                 bus,
    output logic [ADDR_WIDTH-1:0]      o_rom_addr,
    input  wire logic [DATA_WIDTH-1:0] i_rom_data
);

    localparam int c_FRAC_BITS = 14;
    localparam int c_PROD_W    = 2 * DATA_WIDTH;
    localparam logic signed [c_PROD_W-1:0] c_PCM_MAX =
        {{(DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [c_PROD_W-1:0] c_PCM_MIN =
        {{(DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    logic [PHASE_WIDTH-1:0]       r_phase;
    logic [PHASE_WIDTH-1:0]       w_sum;
    logic [PHASE_WIDTH-1:0]       w_dither;
    logic                         r_v1;
    logic [DATA_WIDTH-1:0]        r_env1;
    logic                         r_pulse1;
    logic signed [c_PROD_W-1:0]   w_prod;
    logic signed [c_PROD_W-1:0]   w_scaled;
    logic [DATA_WIDTH-1:0]        w_sat;
    logic [DATA_WIDTH-1:0]        r_pcm;
    logic                         r_pcm_valid;
    logic                         r_pulse;

`ifdef DDFS_DITHER_EN
    localparam int c_DITHER_W = PHASE_WIDTH - ADDR_WIDTH;
    logic [15:0] r_lfsr;

    // Galois form of x^16+x^14+x^13+x^11+1, shifting right.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_lfsr <= 16'hACE1;
        else if (bus.i_en)
            r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
    end

    generate
        if (c_DITHER_W >= 16) begin : g_dither_zext
            assign w_dither = PHASE_WIDTH'(r_lfsr);
        end else begin : g_dither_trunc
            assign w_dither = PHASE_WIDTH'(r_lfsr[c_DITHER_W-1:0]);
        end
    endgenerate
`else
    assign w_dither = '0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_phase <= '0;
        else if (bus.i_en)
            r_phase <= r_phase + bus.i_fccw + bus.i_focw;
    end

    assign w_sum      = r_phase + bus.i_pha + w_dither;
    assign o_rom_addr = w_sum[PHASE_WIDTH-1 -: ADDR_WIDTH];

    // Stage 1 carries the control side alongside the ROM's one-cycle read.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_v1     <= 1'b0;
            r_env1   <= '0;
            r_pulse1 <= 1'b0;
        end else begin
            r_v1     <= bus.i_en;
            r_env1   <= bus.i_env;
            r_pulse1 <= w_sum[PHASE_WIDTH-1];
        end
    end

    assign w_prod   = $signed(i_rom_data) * $signed(r_env1);
    assign w_scaled = w_prod >>> c_FRAC_BITS;

    always_comb begin
        w_sat = w_scaled[DATA_WIDTH-1:0];
        if (w_scaled > c_PCM_MAX)
            w_sat = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        else if (w_scaled < c_PCM_MIN)
            w_sat = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pcm       <= '0;
            r_pcm_valid <= 1'b0;
            r_pulse     <= 1'b0;
        end else begin
            r_pcm_valid <= r_v1;
            if (r_v1) begin
                r_pcm   <= w_sat;
                r_pulse <= r_pulse1;
            end
        end
    end

    assign bus.o_pcm       = r_pcm;
    assign bus.o_pcm_valid = r_pcm_valid;
    assign bus.o_pulse     = r_pulse;

endmodule

`default_nettype wire

// File: doc/ddfs_core.md
Name: ddfs_core

Overview:
Direct digital frequency synthesis engine that drives the read port of the registered sine lookup ROM (16-bit signed samples, 2**ADDR_WIDTH entries, one full cycle, 1-cycle read latency). It keeps a phase accumulator, issues ROM addresses, and re-aligns control inputs to the returning ROM data. It also applies a signed amplitude envelope and produces a validated PCM stream plus a square-wave output. It sits between the control registers and the audio/DAC output path.

Parameters:
PHASE_WIDTH, 30, phase accumulator width in bits
ADDR_WIDTH, 11, ROM address width; must be < PHASE_WIDTH
DATA_WIDTH, 16, ROM sample, envelope and PCM width (signed)

Ports:
i_clk  input  1  system clock, all state on rising edge
i_rst_n  input  1  asynchronous active-low reset
i_en  input  1  advance phase and launch one sample this cycle
i_fccw  input  PHASE_WIDTH  carrier frequency control word (unsigned)
i_focw  input  PHASE_WIDTH  frequency offset control word (two's complement, FM)
i_pha  input  PHASE_WIDTH  phase offset (unsigned, PM)
i_env  input  DATA_WIDTH  amplitude envelope, signed Q2.14
o_rom_addr  output  ADDR_WIDTH  ROM read address
i_rom_data  input  DATA_WIDTH  ROM read data, valid 1 cycle after o_rom_addr
o_pcm  output  DATA_WIDTH  signed output sample
o_pcm_valid  output  1  o_pcm updated this cycle
o_pulse  output  1  square wave: MSB of the offset phase, registered and aligned with o_pcm

Behaviour:
- Reset (async assert, sync release): phase_q=0, all pipeline registers 0; o_pcm=0, o_pcm_valid=0, o_pulse=0. o_rom_addr=0 while in reset (combinational from phase_q=0 and i_pha=0 with dither 0).
- Phase: when i_en=1, phase_q <= phase_q + i_fccw + i_focw, modulo 2**PHASE_WIDTH; carries discarded, natural wrap. When i_en=0, phase_q holds.
- Address (stage 0, combinational): sum_p = phase_q + i_pha (mod 2**PHASE_WIDTH). o_rom_addr = sum_p[PHASE_WIDTH-1 -: ADDR_WIDTH]. Lower bits are truncated, not rounded.
- Stage 1 (aligned with ROM latency): v1 <= i_en; env1 <= i_env; pulse1 <= sum_p[PHASE_WIDTH-1].
- Stage 2:
  - When v1=1: prod = signed(i_rom_data) * signed(env1), full 2*DATA_WIDTH width. scaled = prod >>> 14 (arithmetic shift, floor). o_pcm <= scaled saturated to [-2**(DATA_WIDTH-1), 2**(DATA_WIDTH-1)-1]. o_pulse <= pulse1.
  - o_pcm_valid <= v1 every cycle.
  - When v1=0: o_pcm and o_pulse hold.
- Latency: an i_en at cycle N samples the pre-update phase_q; the matching o_pcm/o_pcm_valid appear at cycle N+2.
- i_en may toggle every cycle: one valid output per i_en pulse, with no bubbles and no merging.
- Envelope alignment: i_env is sampled in the same cycle as the address. A change at cycle N affects only samples launched at N or later.
- Control words may change any cycle and take effect on the next phase update. Negative i_focw exceeding i_fccw gives backward phase travel (modular).
- Reset mid-operation clears all in-flight samples; no valid pulse is emitted for them.

Optional Feature:
DDFS_DITHER_EN
- Defined: 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11+1, seeded 16'hACE1 on reset, advances on each i_en=1 cycle. Its value is zero-extended or truncated to PHASE_WIDTH-ADDR_WIDTH bits and added into sum_p (sum_p = phase_q + i_pha + dither) before truncation, spreading the phase-truncation spurs.
- Not defined: dither = 0, no LFSR logic.

Test Plan:
- Reset, i_en=1, i_fccw=32'h0008_0000, i_focw=0, i_pha=0 -> o_rom_addr = 0,1,2,3,... on consecutive cycles; o_pcm_valid rises 2 cycles after the first i_en.
- i_fccw=32'h2000_0000 -> o_rom_addr alternates 0,1024,0,1024 (wrap); o_pulse alternates 0,1 aligned with o_pcm.
- i_fccw=0, i_pha=32'h2000_0000 -> o_rom_addr constant 1024. i_focw=32'h3FF8_0000 (-2**19) -> address decrements 0,2047,2046,...
- Model ROM with data==addr, i_env=16'h4000 (1.0) -> o_pcm equals the address issued 2 cycles earlier. i_env=16'h2000 with ROM 16'h4000 -> 16'h2000. i_env=16'h8000 (-2.0) with ROM 16'h7FFF -> saturates to 16'h8000.
- i_en pattern 1,0,1,1,0 -> o_pcm_valid 1,0,1,1,0 delayed 2 cycles; phase advances only 3 times; o_pcm holds during invalid cycles.
- Assert i_rst_n=0 with two samples in flight -> o_pcm_valid=0 and o_pcm=0 immediately. After release, the first address is 0.
